// File: rtl/axi_mem_slave.sv
// AXI4 responder backed by a 64-bit-wide memory array for fetch and load/store initiators.
// Independent read and write engines, one outstanding transaction each, INCR/FIXED bursts.
module axi_mem_slave #(
  parameter logic [31:0] ADDR_BASE = 32'h8000_0000,
  parameter int          MEM_WORDS = 65536,
  parameter int          RD_LAT    = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  S_AXI_AWID,
  input  logic [31:0] S_AXI_AWADDR,
  input  logic [7:0]  S_AXI_AWLEN,
  input  logic [2:0]  S_AXI_AWSIZE,
  input  logic [1:0]  S_AXI_AWBURST,
  input  logic        S_AXI_AWVALID,
  output logic        S_AXI_AWREADY,
  input  logic [63:0] S_AXI_WDATA,
  input  logic [7:0]  S_AXI_WSTRB,
  input  logic        S_AXI_WLAST,
  input  logic        S_AXI_WVALID,
  output logic        S_AXI_WREADY,
  output logic [3:0]  S_AXI_BID,
  output logic [1:0]  S_AXI_BRESP,
  output logic        S_AXI_BVALID,
  input  logic        S_AXI_BREADY,
  input  logic [3:0]  S_AXI_ARID,
  input  logic [31:0] S_AXI_ARADDR,
  input  logic [7:0]  S_AXI_ARLEN,
  input  logic [2:0]  S_AXI_ARSIZE,
  input  logic [1:0]  S_AXI_ARBURST,
  input  logic        S_AXI_ARVALID,
  output logic        S_AXI_ARREADY,
  output logic [3:0]  S_AXI_RID,
  output logic [63:0] S_AXI_RDATA,
  output logic [1:0]  S_AXI_RRESP,
  output logic        S_AXI_RLAST,
  output logic        S_AXI_RVALID,
  input  logic        S_AXI_RREADY,
  output logic [3:0]  dbg_state
);

  // Handshakes: a beat transfers on the rising edge where VALID and READY are both high;
  // READY never depends on VALID here, and payload is held stable while VALID & ~READY.

  localparam int          IW    = $clog2(MEM_WORDS);
  localparam logic [31:0] WORDS = 32'(MEM_WORDS);
  localparam logic [3:0]  LAT   = 4'(RD_LAT);

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

  logic [63:0] mem [MEM_WORDS];

  function automatic logic [1:0] beat_resp(input logic [31:0] addr, input logic [1:0] burst,
                                           input logic [2:0] size);
    logic [31:0] off;
    off = addr - ADDR_BASE;
    if (addr < ADDR_BASE || (off >> 3) >= WORDS) return 2'b11;
    if (burst[1] || size > 3'd3) return 2'b10;
    return 2'b00;
  endfunction

  function automatic logic [IW-1:0] word_idx(input logic [31:0] addr);
    return IW'((addr - ADDR_BASE) >> 3);
  endfunction

  function automatic logic [31:0] next_addr(input logic [31:0] addr, input logic [1:0] burst,
                                            input logic [2:0] size);
    return (burst == 2'b01) ? addr + (32'd1 << size) : addr;
  endfunction

  // Response codes order by severity numerically: DECERR 11 > SLVERR 10 > OKAY 00.
  function automatic logic [1:0] worst(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

  logic rst_done;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rst_done <= 1'b0;
    else      rst_done <= 1'b1;
  end

  // ---------------- read engine ----------------
  r_state_t    r_state, r_next;
  logic [31:0] r_addr;
  logic [7:0]  r_len, r_beat;
  logic [2:0]  r_size;
  logic [1:0]  r_burst;
  logic [3:0]  r_cnt;
  logic        ar_hs, r_hs, fetch_en;
  logic [31:0] fetch_addr;
  logic [1:0]  fetch_burst, fetch_rsp;
  logic [2:0]  fetch_size;

  assign S_AXI_ARREADY = rst_done && (r_state == R_IDLE);
  assign S_AXI_RVALID  = (r_state == R_DATA);
  assign S_AXI_RLAST   = S_AXI_RVALID && (r_beat == r_len);
  assign ar_hs         = S_AXI_ARVALID && S_AXI_ARREADY;
  assign r_hs          = S_AXI_RVALID && S_AXI_RREADY;
  assign fetch_rsp     = beat_resp(fetch_addr, fetch_burst, fetch_size);

  always_comb begin
    r_next      = r_state;
    fetch_en    = 1'b0;
    fetch_addr  = r_addr;
    fetch_burst = r_burst;
    fetch_size  = r_size;
    case (r_state)
      R_IDLE: if (ar_hs) begin
        if (RD_LAT == 0) begin
          r_next      = R_DATA;
          fetch_en    = 1'b1;
          fetch_addr  = S_AXI_ARADDR;
          fetch_burst = S_AXI_ARBURST;
          fetch_size  = S_AXI_ARSIZE;
        end else begin
          r_next = R_WAIT;
        end
      end
      R_WAIT: if (r_cnt == LAT - 4'd1) begin
        r_next   = R_DATA;
        fetch_en = 1'b1;
      end
      R_DATA: if (r_hs) begin
        if (S_AXI_RLAST) begin
          r_next = R_IDLE;
        end else begin
          fetch_en   = 1'b1;
          fetch_addr = next_addr(r_addr, r_burst, r_size);
        end
      end
      default: r_next = R_IDLE;
    endcase
  end

  // Fetches sample the array before this edge's write lands, so a colliding read sees old data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= R_IDLE;
      r_addr      <= '0;
      r_len       <= '0;
      r_beat      <= '0;
      r_size      <= '0;
      r_burst     <= '0;
      r_cnt       <= '0;
      S_AXI_RID   <= '0;
      S_AXI_RDATA <= '0;
      S_AXI_RRESP <= '0;
    end else begin
      r_state <= r_next;
      if (ar_hs) begin
        S_AXI_RID <= S_AXI_ARID;
        r_addr    <= S_AXI_ARADDR;
        r_len     <= S_AXI_ARLEN;
        r_size    <= S_AXI_ARSIZE;
        r_burst   <= S_AXI_ARBURST;
        r_beat    <= '0;
        r_cnt     <= '0;
      end
      if (r_state == R_WAIT) r_cnt <= r_cnt + 4'd1;
      if (r_hs && !S_AXI_RLAST) r_beat <= r_beat + 8'd1;
      if (fetch_en) begin
        r_addr      <= fetch_addr;
        S_AXI_RRESP <= fetch_rsp;
        S_AXI_RDATA <= (fetch_rsp == 2'b00) ? mem[word_idx(fetch_addr)] : 64'd0;
      end
    end
  end

  // ---------------- write engine ----------------
  w_state_t    w_state, w_next;
  logic [31:0] w_addr;
  logic [7:0]  w_len, w_beat;
  logic [2:0]  w_size;
  logic [1:0]  w_burst, w_rsp;
  logic        aw_hs, w_hs, w_last, w_lerr, mem_we;

  assign S_AXI_AWREADY = rst_done && (w_state == W_IDLE);
  assign S_AXI_WREADY  = (w_state == W_DATA);
  assign S_AXI_BVALID  = (w_state == W_RESP);
  assign aw_hs         = S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_hs          = S_AXI_WVALID && S_AXI_WREADY;
  assign w_last        = (w_beat == w_len);
  assign w_lerr        = (S_AXI_WLAST != w_last);
  assign w_rsp         = beat_resp(w_addr, w_burst, w_size);
  assign mem_we        = w_hs && (w_rsp == 2'b00);

  always_comb begin
    w_next = w_state;
    case (w_state)
      W_IDLE:  if (aw_hs) w_next = W_DATA;
      W_DATA:  if (w_hs && w_last) w_next = W_RESP;
      W_RESP:  if (S_AXI_BREADY) w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      w_state     <= W_IDLE;
      w_addr      <= '0;
      w_len       <= '0;
      w_beat      <= '0;
      w_size      <= '0;
      w_burst     <= '0;
      S_AXI_BID   <= '0;
      S_AXI_BRESP <= '0;
    end else begin
      w_state <= w_next;
      if (aw_hs) begin
        S_AXI_BID   <= S_AXI_AWID;
        S_AXI_BRESP <= 2'b00;
        w_addr      <= S_AXI_AWADDR;
        w_len       <= S_AXI_AWLEN;
        w_size      <= S_AXI_AWSIZE;
        w_burst     <= S_AXI_AWBURST;
        w_beat      <= '0;
      end
      if (w_hs) begin
        w_addr      <= next_addr(w_addr, w_burst, w_size);
        w_beat      <= w_beat + 8'd1;
        S_AXI_BRESP <= worst(S_AXI_BRESP, worst(w_rsp, w_lerr ? 2'b10 : 2'b00));
      end
    end
  end

  // The array has no reset: contents survive a reset pulse.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 8; b++) begin
        if (S_AXI_WSTRB[b]) mem[word_idx(w_addr)][8*b +: 8] <= S_AXI_WDATA[8*b +: 8];
      end
    end
  end

  assign dbg_state = {w_state, r_state};

endmodule
